// File: rtl/acesso_pkg.sv
// Shared definitions for the vehicle entry-gate controller: FSM state
// encoding, default lot/timer sizing and a small state decode helper.
package acesso_pkg;

    // Gate sequencer states; both "barrier open" states share bit 1 so the
    // open decode is a single register bit.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        AGUARDA  = 2'd1,
        ABERTA   = 2'd2,
        PASSAGEM = 2'd3
    } estado_t;

    localparam int VAGAS_PADRAO      = 8;
    localparam int CNT_W_PADRAO      = 4;
    localparam int T_ABERTURA_PADRAO = 16;
    localparam int TMR_W_PADRAO      = 5;

    // True while the barrier arm is raised (waiting for the car or car passing).
    function automatic logic cancela_aberta(input estado_t estado);
        return (estado == ABERTA) || (estado == PASSAGEM);
    endfunction

endpackage

// File: rtl/contador_de_ocupacao.sv
// Saturating up/down occupancy counter for the parking lot. Simultaneous
// entry and exit cancel out; the count never wraps below zero or above
// the lot capacity.
module contador_de_ocupacao
    import acesso_pkg::*;
#(
    parameter int VAGAS = VAGAS_PADRAO,
    parameter int CNT_W = CNT_W_PADRAO
) (
    input  logic             CLK,
    input  logic             ON_OFF,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] contagem,
    output logic             lotado
);

    localparam logic [CNT_W-1:0] CAPACIDADE = CNT_W'(VAGAS);
    localparam logic [CNT_W-1:0] UM         = CNT_W'(1);

    // Count register: entries and exits adjust it, with saturation at both ends.
    always_ff @(posedge CLK or negedge ON_OFF) begin
        if (!ON_OFF) begin
            contagem <= '0;
        end else if (inc && !dec) begin
            if (contagem != CAPACIDADE) begin
                contagem <= contagem + UM;
            end
        end else if (dec && !inc) begin
            if (contagem != '0) begin
                contagem <= contagem - UM;
            end
        end
    end

    assign lotado = (contagem == CAPACIDADE);

endmodule

// File: rtl/controlador_de_acesso.sv
// Entry-gate sequencer: takes a car from detection through credential
// check, barrier open, pass-through and close, tracks lot occupancy and
// arms the alert lights only while the barrier is open.
module controlador_de_acesso
    import acesso_pkg::*;
#(
    parameter int VAGAS      = VAGAS_PADRAO,
    parameter int CNT_W      = CNT_W_PADRAO,
    parameter int T_ABERTURA = T_ABERTURA_PADRAO,
    parameter int TMR_W      = TMR_W_PADRAO
) (
    input  logic             CLK,
    input  logic             ON_OFF,
    input  logic             SENSOR_PRESENCA,
    input  logic             ACESSO_VALIDO,
    input  logic             SENSOR_EXTERNO,
    input  logic             SAIDA_VEICULO,
    output logic             ABRIR_CANCELA,
    output logic             HABILITA_LUZES,
    output logic             LOTADO,
    output logic             NEGADO,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] OCUPACAO
);

    localparam logic [TMR_W-1:0] TMR_LIMITE = TMR_W'(T_ABERTURA - 1);
    localparam logic [TMR_W-1:0] TMR_UM     = TMR_W'(1);

    estado_t          estado;
    estado_t          proximo;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_prox;
    logic             negado_prox;
    logic             timeout_prox;
    logic             entrada;

    // State, open-timer and pulse registers; power-off returns everything to rest.
    always_ff @(posedge CLK or negedge ON_OFF) begin
        if (!ON_OFF) begin
            estado  <= OCIOSO;
            timer   <= '0;
            NEGADO  <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            estado  <= proximo;
            timer   <= timer_prox;
            NEGADO  <= negado_prox;
            TIMEOUT <= timeout_prox;
        end
    end

    // Next-state logic: presence loss beats credentials, a car in the arm
    // zone beats the timeout, and the barrier never closes on a car.
    always_comb begin
        proximo      = estado;
        timer_prox   = timer;
        negado_prox  = 1'b0;
        timeout_prox = 1'b0;
        entrada      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (SENSOR_PRESENCA) begin
                    proximo = AGUARDA;
                end
            end
            AGUARDA: begin
                if (!SENSOR_PRESENCA) begin
                    proximo = OCIOSO;
                end else if (ACESSO_VALIDO) begin
                    if (LOTADO) begin
                        negado_prox = 1'b1;
                    end else begin
                        proximo    = ABERTA;
                        timer_prox = '0;
                    end
                end
            end
            ABERTA: begin
                if (SENSOR_EXTERNO) begin
                    proximo = PASSAGEM;
                end else if (timer == TMR_LIMITE) begin
                    proximo      = OCIOSO;
                    timeout_prox = 1'b1;
                end else begin
                    timer_prox = timer + TMR_UM;
                end
            end
            PASSAGEM: begin
                if (!SENSOR_EXTERNO) begin
                    proximo = OCIOSO;
                    entrada = 1'b1;
                end
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    assign ABRIR_CANCELA  = cancela_aberta(estado);
    assign HABILITA_LUZES = ABRIR_CANCELA;

    contador_de_ocupacao #(
        .VAGAS (VAGAS),
        .CNT_W (CNT_W)
    ) u_contador (
        .CLK      (CLK),
        .ON_OFF   (ON_OFF),
        .inc      (entrada),
        .dec      (SAIDA_VEICULO),
        .contagem (OCUPACAO),
        .lotado   (LOTADO)
    );

endmodule

// File: tb/tb_controlador_de_acesso.sv
// Self-checking bench for the entry-gate sequencer: vector table, directed
// corner-case sequences and randomized traffic against a behavioural model.
module tb_controlador_de_acesso;

    localparam int VAGAS = 8;
    localparam int CNT_W = 4;
    localparam int T_AB  = 16;
    localparam int TMR_W = 5;

    logic             CLK    = 1'b0;
    logic             ON_OFF = 1'b0;
    logic             pres   = 1'b0;
    logic             valido = 1'b0;
    logic             ext    = 1'b0;
    logic             saida  = 1'b0;
    logic             abrir;
    logic             luzes;
    logic             lotado;
    logic             negado;
    logic             timeout;
    logic [CNT_W-1:0] ocup;

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural model: where the car is in its journey, how many cycles
    // the arm has been up, lot count and last-cycle pulses.
    localparam int M_LIVRE    = 0;
    localparam int M_ESPERA   = 1;
    localparam int M_ABERTA   = 2;
    localparam int M_PASSANDO = 3;
    int mPhase;
    int mOpenCycles;
    int mOcc;
    bit mNeg;
    bit mTmo;

    typedef struct {
        logic  p;
        logic  v;
        logic  e;
        logic  s;
        logic  expAbrir;
        logic  expNeg;
        logic  expTmo;
        int    expOcc;
        string name;
    } vec_t;

    vec_t vecs[11];

    controlador_de_acesso #(
        .VAGAS      (VAGAS),
        .CNT_W      (CNT_W),
        .T_ABERTURA (T_AB),
        .TMR_W      (TMR_W)
    ) dut (
        .CLK             (CLK),
        .ON_OFF          (ON_OFF),
        .SENSOR_PRESENCA (pres),
        .ACESSO_VALIDO   (valido),
        .SENSOR_EXTERNO  (ext),
        .SAIDA_VEICULO   (saida),
        .ABRIR_CANCELA   (abrir),
        .HABILITA_LUZES  (luzes),
        .LOTADO          (lotado),
        .NEGADO          (negado),
        .TIMEOUT         (timeout),
        .OCUPACAO        (ocup)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(logic p, logic v, logic e, logic s,
                                   logic ea, logic en, logic et, int eo, string n);
        vec_t r;
        r.p = p; r.v = v; r.e = e; r.s = s;
        r.expAbrir = ea; r.expNeg = en; r.expTmo = et; r.expOcc = eo; r.name = n;
        return r;
    endfunction

    task automatic modelReset();
        mPhase      = M_LIVRE;
        mOpenCycles = 0;
        mOcc        = 0;
        mNeg        = 0;
        mTmo        = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        bit entered;
        entered = 0;
        mNeg    = 0;
        mTmo    = 0;
        if (mPhase == M_LIVRE) begin
            if (pres) mPhase = M_ESPERA;
        end else if (mPhase == M_ESPERA) begin
            if (!pres) begin
                mPhase = M_LIVRE;
            end else if (valido) begin
                if (mOcc >= VAGAS) begin
                    mNeg = 1;
                end else begin
                    mPhase      = M_ABERTA;
                    mOpenCycles = 1;
                end
            end
        end else if (mPhase == M_ABERTA) begin
            if (ext) begin
                mPhase = M_PASSANDO;
            end else if (mOpenCycles >= T_AB) begin
                mPhase = M_LIVRE;
                mTmo   = 1;
            end else begin
                mOpenCycles++;
            end
        end else begin
            if (!ext) begin
                mPhase  = M_LIVRE;
                entered = 1;
            end
        end
        if (entered && !saida) mOcc = (mOcc + 1 > VAGAS) ? VAGAS : mOcc + 1;
        else if (saida && !entered) mOcc = (mOcc - 1 < 0) ? 0 : mOcc - 1;
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic checkAgainstModel(string tag);
        bit open;
        open = (mPhase == M_ABERTA) || (mPhase == M_PASSANDO);
        checkOutput({tag, "_abrir"},   abrir,   open);
        checkOutput({tag, "_luzes"},   luzes,   open);
        checkOutput({tag, "_negado"},  negado,  mNeg);
        checkOutput({tag, "_timeout"}, timeout, mTmo);
        checkOutput({tag, "_ocup"},    ocup,    mOcc);
        checkOutput({tag, "_lotado"},  lotado,  mOcc == VAGAS);
    endtask

    // Drive one cycle of inputs, let an edge sample them, sample outputs 1 unit later.
    task automatic applyStimulus(logic p, logic v, logic e, logic s);
        pres   = p;
        valido = v;
        ext    = e;
        saida  = s;
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        @(negedge CLK);
        ON_OFF = 1'b0;
        pres = 0; valido = 0; ext = 0; saida = 0;
        modelReset();
        #2;
        checkOutput("rst_abrir",   abrir,   0);
        checkOutput("rst_luzes",   luzes,   0);
        checkOutput("rst_negado",  negado,  0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_ocup",    ocup,    0);
        checkOutput("rst_lotado",  lotado,  0);
        @(negedge CLK);
        ON_OFF = 1'b1;
    endtask

    task automatic doEntry();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        int openCount;
        bit tmoAtClose;
        bit tmoEarly;

        modelReset();
        doReset();

        // Basic entry with a 3-cycle pass-through, then presence drop racing a credential.
        vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0, "v0_detect");
        vecs[1]  = mkVec(1, 1, 0, 0, 1, 0, 0, 0, "v1_open");
        vecs[2]  = mkVec(1, 0, 1, 0, 1, 0, 0, 0, "v2_pass1");
        vecs[3]  = mkVec(0, 0, 1, 0, 1, 0, 0, 0, "v3_pass2");
        vecs[4]  = mkVec(0, 0, 1, 0, 1, 0, 0, 0, "v4_pass3");
        vecs[5]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1, "v5_close");
        vecs[6]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1, "v6_detect");
        vecs[7]  = mkVec(0, 1, 0, 0, 0, 0, 0, 1, "v7_droprace");
        vecs[8]  = mkVec(0, 1, 0, 0, 0, 0, 0, 1, "v8_idlevalid");
        vecs[9]  = mkVec(0, 0, 0, 1, 0, 0, 0, 0, "v9_exit");
        vecs[10] = mkVec(0, 0, 0, 1, 0, 0, 0, 0, "v10_underflow");

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].p, vecs[i].v, vecs[i].e, vecs[i].s);
            checkOutput({vecs[i].name, "_abrir"},   abrir,   vecs[i].expAbrir);
            checkOutput({vecs[i].name, "_luzes"},   luzes,   vecs[i].expAbrir);
            checkOutput({vecs[i].name, "_negado"},  negado,  vecs[i].expNeg);
            checkOutput({vecs[i].name, "_timeout"}, timeout, vecs[i].expTmo);
            checkOutput({vecs[i].name, "_ocup"},    ocup,    vecs[i].expOcc);
        end

        // Timeout: arm up with no car; presence drops and credentials keep coming.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        openCount  = abrir ? 1 : 0;
        tmoAtClose = 0;
        tmoEarly   = timeout;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 0, 0);
            if (abrir) begin
                openCount++;
                if (timeout) tmoEarly = 1;
            end else begin
                tmoAtClose = timeout;
                break;
            end
        end
        checkOutput("tmo_open_cycles", openCount, T_AB);
        checkOutput("tmo_pulse",       tmoAtClose, 1);
        checkOutput("tmo_not_early",   tmoEarly, 0);
        checkOutput("tmo_ocup",        ocup, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("tmo_pulse_width", timeout, 0);

        // Fill the lot, then a refused credential.
        for (int i = 0; i < VAGAS; i++) doEntry();
        checkOutput("full_ocup",   ocup, VAGAS);
        checkOutput("full_lotado", lotado, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("deny_negado", negado, 1);
        checkOutput("deny_abrir",  abrir, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("deny_pulse_width", negado, 0);
        checkOutput("deny_abrir2",      abrir, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("deny_still_waiting", negado, 1);
        checkAgainstModel("deny");

        // Exits down to 5, then an entry completing on the same edge as an exit.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("exit_ocup5",   ocup, 5);
        checkOutput("exit_lotado0", lotado, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("net0_ocup",  ocup, 5);
        checkOutput("net0_abrir", abrir, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("drain_ocup", ocup, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("underflow_ocup", ocup, 0);

        // Power-off in the middle of a pass-through must clear outputs without an edge.
        doReset();
        for (int i = 0; i < 3; i++) doEntry();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("pwr_pre_abrir", abrir, 1);
        checkOutput("pwr_pre_ocup",  ocup, 3);
        #2;
        ON_OFF = 1'b0;
        modelReset();
        #1;
        checkOutput("pwr_abrir", abrir, 0);
        checkOutput("pwr_luzes", luzes, 0);
        checkOutput("pwr_ocup",  ocup, 0);
        @(negedge CLK);
        ext    = 1'b0;
        ON_OFF = 1'b1;

        // Randomized traffic against the behavioural model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
            checkAgainstModel("rnd");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
